// File: rtl/audio_pkg.sv
// ----------------------------------------------------------------------------
// audio_pkg
// Shared definitions for the audio output path: default sample width, gain
// format, the DAC writer state type and the soft-mute gain step helper.
// ----------------------------------------------------------------------------
package audio_pkg;

  localparam int unsigned DATA_W = 32;

  // Gain is 9-bit unsigned, 0..256, where 256 means unity.
  localparam int unsigned GAIN_W = 9;
  localparam logic [GAIN_W-1:0] GAIN_UNITY = 9'd256;

  typedef enum logic {
    PRIME,
    RUN
  } dac_state_t;

  // One step of the soft-mute ramp toward silence (mute=1) or unity (mute=0).
  function automatic logic [GAIN_W-1:0] gain_step(input logic [GAIN_W-1:0] gain,
                                                  input logic mute);
    logic [GAIN_W-1:0] next;
    next = gain;
    if (mute) begin
      if (gain != '0) next = gain - 1'b1;
    end else begin
      if (gain < GAIN_UNITY) next = gain + 1'b1;
    end
    return next;
  endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// ----------------------------------------------------------------------------
// audio_sample_fifo
// Synchronous FIFO holding packed stereo frames. The head entry is presented
// combinationally on o_rdata so the caller can consume it in the pop cycle.
// Pointers carry one extra wrap bit so full and empty can be told apart.
//
// Ports:
//   sample_clk  in   clock, rising edge
//   resetn      in   asynchronous active-low reset of the pointers
//   i_push      in   write i_wdata this cycle (caller guarantees room)
//   i_pop       in   advance the read pointer (caller guarantees not empty)
//   i_wdata     in   frame to store
//   o_rdata     out  frame at the head of the FIFO
//   o_level     out  number of frames stored
//   o_full      out  level equals DEPTH
//   o_empty     out  level equals 0
// ----------------------------------------------------------------------------
module audio_sample_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     sample_clk,
  input  logic                     resetn,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge sample_clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage is not reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge sample_clk) begin
    if (i_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr[AW-1:0]];
  assign o_level = r_wptr - r_rptr;
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule

// File: rtl/audio_dac_writer.sv
// ----------------------------------------------------------------------------
// audio_dac_writer
// Output sink of the effect chain. Buffers stereo frames, drains them into
// the codec DAC write port when audio_out_allowed is high, applies a
// soft-mute gain ramp (one step per written frame) and counts overflow and
// underrun events.
//
// Ports:
//   sample_clk               in   clock, rising edge
//   resetn                   in   asynchronous active-low reset
//   in_valid                 in   new stereo frame present
//   in_left, in_right        in   signed input samples
//   mute                     in   1 = ramp to silence, 0 = ramp to unity
//   audio_out_allowed        in   codec can take a frame this cycle
//   write_audio_out          out  one-cycle write strobe to the codec
//   left/right_channel_audio_out out scaled frame, valid with the strobe
//   fifo_level               out  frames currently buffered
//   overflow_cnt             out  dropped input frames, saturating
//   underrun_cnt             out  underrun events, saturating
//   muted                    out  gain has been 0 (lags gain by one edge)
// ----------------------------------------------------------------------------
module audio_dac_writer
  import audio_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = audio_pkg::DATA_W
) (
  input  logic                   sample_clk,
  input  logic                   resetn,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_left,
  input  logic [DATA_W-1:0]      in_right,
  input  logic                   mute,
  input  logic                   audio_out_allowed,
  output logic                   write_audio_out,
  output logic [DATA_W-1:0]      left_channel_audio_out,
  output logic [DATA_W-1:0]      right_channel_audio_out,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [15:0]            overflow_cnt,
  output logic [15:0]            underrun_cnt,
  output logic                   muted
);

  localparam int unsigned LVL_W  = $clog2(DEPTH) + 1;
  localparam int unsigned PROD_W = DATA_W + 10;
  localparam logic [LVL_W-1:0] HALF_LEVEL = LVL_W'(DEPTH / 2);

  dac_state_t r_state;
  dac_state_t w_state_next;

  logic                w_pop;
  logic                w_push;
  logic                w_underrun;
  logic                w_overflow;
  logic                w_full;
  logic                w_empty;
  logic [LVL_W-1:0]    w_level;
  logic [2*DATA_W-1:0] w_head;

  logic [GAIN_W-1:0]   r_gain;
  logic                r_muted;
  logic                r_write;
  logic [DATA_W-1:0]   r_left;
  logic [DATA_W-1:0]   r_right;
  logic [15:0]         r_overflow_cnt;
  logic [15:0]         r_underrun_cnt;

  logic [PROD_W-1:0]   w_samp_l;
  logic [PROD_W-1:0]   w_samp_r;
  logic [PROD_W-1:0]   w_gain_ext;
  logic [PROD_W-1:0]   w_prod_l;
  logic [PROD_W-1:0]   w_prod_r;

  // ---------------------------------------------------------------- FIFO
  audio_sample_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * DATA_W)
  ) u_fifo (
    .sample_clk (sample_clk),
    .resetn     (resetn),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_wdata    ({in_left, in_right}),
    .o_rdata    (w_head),
    .o_level    (w_level),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // A full FIFO still accepts a frame when the head leaves in the same cycle.
  assign w_push     = in_valid && (!w_full || w_pop);
  assign w_overflow = in_valid && w_full && !w_pop;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge sample_clk or negedge resetn) begin
    if (!resetn) r_state <= PRIME;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_underrun   = 1'b0;
    unique case (r_state)
      PRIME: begin
        if (w_level >= HALF_LEVEL) w_state_next = RUN;
      end
      RUN: begin
        if (audio_out_allowed) begin
          if (!w_empty) begin
            w_pop = 1'b1;
          end else begin
            // Leaving RUN makes this a single event rather than one per cycle.
            w_underrun   = 1'b1;
            w_state_next = PRIME;
          end
        end
      end
      default: w_state_next = PRIME;
    endcase
  end

  // ---------------------------------------------------------------- scaling
  // Equal-width operands: the low PROD_W bits of the product are the same
  // for signed and unsigned interpretation, so a plain multiply suffices.
  assign w_samp_l   = {{10{w_head[2*DATA_W-1]}}, w_head[2*DATA_W-1:DATA_W]};
  assign w_samp_r   = {{10{w_head[DATA_W-1]}}, w_head[DATA_W-1:0]};
  assign w_gain_ext = {{(PROD_W - GAIN_W){1'b0}}, r_gain};
  assign w_prod_l   = w_samp_l * w_gain_ext;
  assign w_prod_r   = w_samp_r * w_gain_ext;

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge sample_clk or negedge resetn) begin
    if (!resetn) begin
      r_write <= 1'b0;
      r_left  <= '0;
      r_right <= '0;
      r_gain  <= '0;
      r_muted <= 1'b1;
    end else begin
      r_write <= w_pop;
      r_muted <= (r_gain == '0);
      if (w_pop) begin
        // Arithmetic >>> 8, keeping the low DATA_W bits.
        r_left  <= w_prod_l[DATA_W+7:8];
        r_right <= w_prod_r[DATA_W+7:8];
        r_gain  <= gain_step(r_gain, mute);
      end
    end
  end

  // ---------------------------------------------------------------- counters
  always_ff @(posedge sample_clk or negedge resetn) begin
    if (!resetn) begin
      r_overflow_cnt <= '0;
      r_underrun_cnt <= '0;
    end else begin
      if (w_overflow && (r_overflow_cnt != 16'hFFFF)) r_overflow_cnt <= r_overflow_cnt + 1'b1;
      if (w_underrun && (r_underrun_cnt != 16'hFFFF)) r_underrun_cnt <= r_underrun_cnt + 1'b1;
    end
  end

  assign write_audio_out         = r_write;
  assign left_channel_audio_out  = r_left;
  assign right_channel_audio_out = r_right;
  assign fifo_level              = w_level;
  assign overflow_cnt            = r_overflow_cnt;
  assign underrun_cnt            = r_underrun_cnt;
  assign muted                   = r_muted;

endmodule

// File: tb/tb_audio_dac_writer.sv
// ----------------------------------------------------------------------------
// tb_audio_dac_writer
// Self-checking bench: a frame queue plus a few integers model the writer
// cycle by cycle; every DUT output is compared after each clock edge.
// ----------------------------------------------------------------------------
module tb_audio_dac_writer;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned DATA_W = 32;

  logic              sample_clk = 1'b0;
  logic              resetn;
  logic              in_valid;
  logic [DATA_W-1:0] in_left;
  logic [DATA_W-1:0] in_right;
  logic              mute;
  logic              audio_out_allowed;
  logic              write_audio_out;
  logic [DATA_W-1:0] left_channel_audio_out;
  logic [DATA_W-1:0] right_channel_audio_out;
  logic [4:0]        fifo_level;
  logic [15:0]       overflow_cnt;
  logic [15:0]       underrun_cnt;
  logic              muted;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [63:0] m_q[$];
  int          m_gain;
  bit          m_run;
  int          m_ovf;
  int          m_unr;

  always #5 sample_clk = ~sample_clk;

  audio_dac_writer #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) dut (
    .sample_clk              (sample_clk),
    .resetn                  (resetn),
    .in_valid                (in_valid),
    .in_left                 (in_left),
    .in_right                (in_right),
    .mute                    (mute),
    .audio_out_allowed       (audio_out_allowed),
    .write_audio_out         (write_audio_out),
    .left_channel_audio_out  (left_channel_audio_out),
    .right_channel_audio_out (right_channel_audio_out),
    .fifo_level              (fifo_level),
    .overflow_cnt            (overflow_cnt),
    .underrun_cnt            (underrun_cnt),
    .muted                   (muted)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // sample * gain / 256 rounded toward minus infinity, truncated to 32 bits.
  function automatic logic [31:0] ref_scale(input logic [31:0] s, input int g);
    longint p;
    p = longint'($signed(s)) * longint'(g);
    p = p >>> 8;
    return p[31:0];
  endfunction

  task automatic do_reset();
    resetn = 1'b0;
    in_valid = 1'b0;
    #1;
    check_eq("rst_wr",    write_audio_out, 0);
    check_eq("rst_left",  left_channel_audio_out, 0);
    check_eq("rst_right", right_channel_audio_out, 0);
    check_eq("rst_level", fifo_level, 0);
    check_eq("rst_ovf",   overflow_cnt, 0);
    check_eq("rst_unr",   underrun_cnt, 0);
    check_eq("rst_muted", muted, 1);
    m_q.delete();
    m_gain = 0;
    m_run  = 1'b0;
    m_ovf  = 0;
    m_unr  = 0;
    repeat (2) @(posedge sample_clk);
    #1;
    resetn = 1'b1;
  endtask

  // Apply one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input bit v, input logic [31:0] l, input logic [31:0] r,
                      input bit m, input bit a);
    int          sz;
    bit          pop;
    bit          exp_wr;
    bit          exp_muted;
    logic [63:0] f;
    logic [31:0] exp_l;
    logic [31:0] exp_r;
    in_valid          = v;
    in_left           = l;
    in_right          = r;
    mute              = m;
    audio_out_allowed = a;

    sz        = m_q.size();
    pop       = m_run && a && (sz > 0);
    exp_wr    = pop;
    exp_muted = (m_gain == 0);
    exp_l     = '0;
    exp_r     = '0;
    if (pop) begin
      f     = m_q.pop_front();
      exp_l = ref_scale(f[63:32], m_gain);
      exp_r = ref_scale(f[31:0], m_gain);
      if (m && m_gain > 0) m_gain--;
      else if (!m && m_gain < 256) m_gain++;
    end
    if (v) begin
      if (sz < DEPTH || pop) m_q.push_back({l, r});
      else if (m_ovf < 65535) m_ovf++;
    end
    if (!m_run) begin
      m_run = (sz >= DEPTH / 2);
    end else if (a && sz == 0) begin
      m_run = 1'b0;
      if (m_unr < 65535) m_unr++;
    end

    @(posedge sample_clk);
    #1;
    check_eq("wr", write_audio_out, exp_wr);
    if (exp_wr) begin
      check_eq("left",  left_channel_audio_out, exp_l);
      check_eq("right", right_channel_audio_out, exp_r);
    end
    check_eq("level", fifo_level, m_q.size());
    check_eq("ovf",   overflow_cnt, m_ovf);
    check_eq("unr",   underrun_cnt, m_unr);
    check_eq("muted", muted, exp_muted);
  endtask

  initial begin
    bit m_rnd;
    resetn            = 1'b1;
    in_valid          = 1'b0;
    in_left           = '0;
    in_right          = '0;
    mute              = 1'b0;
    audio_out_allowed = 1'b0;
    #3;
    do_reset();

    // Fill-then-drain ramp from gain 0 up to unity.
    for (int i = 0; i < 300; i++) step(1, 32'h0001_0000, 32'hFFFF_0000, 0, 1);
    for (int i = 0; i < 20; i++) step(1, $urandom, $urandom, 0, 1);

    // Overflow with the codec stalled, then push+pop on a full FIFO.
    for (int i = 0; i < 20; i++) step(1, $urandom, $urandom, 0, 0);
    for (int i = 0; i < 3; i++) step(1, $urandom, $urandom, 0, 1);

    // Drain into underrun, then refill.
    for (int i = 0; i < 30; i++) step(0, '0, '0, 0, 1);
    for (int i = 0; i < 12; i++) step(1, $urandom, $urandom, 0, 1);

    // Mute ramp down, then back up.
    for (int i = 0; i < 300; i++) step(1, $urandom, $urandom, 1, 1);
    for (int i = 0; i < 10; i++) step(1, $urandom, $urandom, 0, 1);

    // Randomized traffic.
    m_rnd = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(63) == 0) m_rnd = ~m_rnd;
      step(($urandom_range(3) != 0), $urandom, $urandom, m_rnd,
           ($urandom_range(3) != 0));
    end

    // Reset asserted while a strobe is pending and level is 10.
    do_reset();
    for (int i = 0; i < 10; i++) step(1, $urandom, $urandom, 0, 0);
    for (int i = 0; i < 2; i++) step(1, $urandom, $urandom, 0, 1);
    check_eq("pre_rst_wr",    write_audio_out, 1);
    check_eq("pre_rst_level", fifo_level, 10);
    do_reset();
    for (int i = 0; i < 5; i++) step(0, '0, '0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
